// File: rtl/keypad_pkg.sv
// Shared state type, panel constants and key-map helpers for the front-panel keypad scanner.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 3;
    localparam logic [3:0] KEY_CANCEL = 4'hA;
    localparam logic [3:0] KEY_START  = 4'hB;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } kp_state_e;

    // Rows 0..2 carry digits 1..9 in reading order; row 3 is CANCEL / 0 / START.
    function automatic logic [3:0] key_decode(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        if (row == 2'd3) begin
            case (col)
                2'd0:    code = KEY_CANCEL;
                2'd1:    code = 4'h0;
                2'd2:    code = KEY_START;
                default: code = 4'h0;
            endcase
        end else begin
            code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
        end
        return code;
    endfunction

    function automatic logic [1:0] col_index(input logic [NUM_COLS-1:0] col_oh);
        logic [1:0] idx;
        case (col_oh)
            3'b001:  idx = 2'd0;
            3'b010:  idx = 2'd1;
            3'b100:  idx = 2'd2;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic col_onehot(input logic [NUM_COLS-1:0] col);
        return (col == 3'b001) || (col == 3'b010) || (col == 3'b100);
    endfunction

    function automatic logic [NUM_ROWS-1:0] row_onehot(input logic [1:0] row);
        return 4'b0001 << row;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous panel inputs, cleared synchronously to zero.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two back-to-back stages give the first flop a full cycle to resolve.
    always_ff @(posedge clk) begin
        if (clear) begin
            meta_q <= {WIDTH{1'b0}};
            sync_q <= {WIDTH{1'b0}};
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x3 keypad scanner with shared press/release debounce; one key_valid pulse per accepted press.
// Define KEYPAD_AUTOREPEAT_EN to add auto-repeat of held digit keys.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SCAN_DWELL      = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic                clk,
    input  logic                clear,
    output logic [NUM_ROWS-1:0] row_out,
    input  logic [NUM_COLS-1:0] col_in,
    output logic [3:0]          key_code,
    output logic                key_valid,
    output logic                key_held
);

    localparam int MAX_A   = (DEBOUNCE_CYCLES > SCAN_DWELL) ? DEBOUNCE_CYCLES : SCAN_DWELL;
    localparam int MAX_B   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(MAX_CNT) + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_ONE;
    endfunction

    logic [NUM_COLS-1:0] col_s;
    kp_state_e           state_q;
    logic [1:0]          row_idx_q;
    logic [NUM_ROWS-1:0] row_out_q;
    logic [NUM_COLS-1:0] cap_oh_q;
    logic [CNT_W-1:0]    dwell_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [3:0]          key_code_q;
    logic                key_valid_q;
    logic                key_held_q;

    logic [1:0]          row_nxt_d;
    logic [CNT_W-1:0]    dwell_inc_d;
    logic [CNT_W-1:0]    cnt_inc_d;
    logic                cap_hit_d;
    logic                rpt_fire_d;

    sync_2ff #(.WIDTH(NUM_COLS)) u_col_sync (
        .clk   (clk),
        .clear (clear),
        .d_i   (col_in),
        .q_o   (col_s)
    );

    assign row_nxt_d   = row_idx_q + 2'd1;
    assign dwell_inc_d = sat_inc(dwell_q);
    assign cnt_inc_d   = sat_inc(cnt_q);
    assign cap_hit_d   = |(col_s & cap_oh_q);

`ifdef KEYPAD_AUTOREPEAT_EN
    logic [CNT_W-1:0] rpt_q;
    logic             rpt_first_q;
    logic [CNT_W-1:0] rpt_inc_d;
    logic [CNT_W-1:0] rpt_target_d;

    assign rpt_inc_d    = sat_inc(rpt_q);
    assign rpt_target_d = rpt_first_q ? CNT_W'(REPEAT_DELAY) : CNT_W'(REPEAT_PERIOD);
    assign rpt_fire_d   = (state_q == HELD) && cap_hit_d && (key_code_q <= 4'h9)
                          && (rpt_inc_d == rpt_target_d);

    // Repeat timer: restarts at every HELD entry, first interval is the longer delay.
    always_ff @(posedge clk) begin
        if (clear) begin
            rpt_q       <= CNT_ZERO;
            rpt_first_q <= 1'b1;
        end else if ((state_q != HELD) || !cap_hit_d) begin
            rpt_q       <= CNT_ZERO;
            rpt_first_q <= 1'b1;
        end else if (rpt_fire_d) begin
            rpt_q       <= CNT_ZERO;
            rpt_first_q <= 1'b0;
        end else begin
            rpt_q       <= rpt_inc_d;
        end
    end
`else
    assign rpt_fire_d = 1'b0;
`endif

    // Scan/debounce state machine; all outputs registered here.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= SCAN;
            row_idx_q   <= 2'd0;
            row_out_q   <= 4'b0001;
            cap_oh_q    <= 3'b000;
            dwell_q     <= CNT_ZERO;
            cnt_q       <= CNT_ZERO;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            case (state_q)
                SCAN: begin
                    if (dwell_q == CNT_W'(SCAN_DWELL - 1)) begin
                        dwell_q <= CNT_ZERO;
                        if (col_onehot(col_s)) begin
                            cap_oh_q <= col_s;
                            cnt_q    <= CNT_ZERO;
                            state_q  <= PRESS_DB;
                        end else begin
                            row_idx_q <= row_nxt_d;
                            row_out_q <= row_onehot(row_nxt_d);
                        end
                    end else begin
                        dwell_q <= dwell_inc_d;
                    end
                end
                PRESS_DB: begin
                    if (col_s == cap_oh_q) begin
                        if (cnt_inc_d == CNT_W'(DEBOUNCE_CYCLES)) begin
                            key_code_q  <= key_decode(row_idx_q, col_index(cap_oh_q));
                            key_valid_q <= 1'b1;
                            key_held_q  <= 1'b1;
                            cnt_q       <= CNT_ZERO;
                            state_q     <= HELD;
                        end else begin
                            cnt_q <= cnt_inc_d;
                        end
                    end else begin
                        row_idx_q <= row_nxt_d;
                        row_out_q <= row_onehot(row_nxt_d);
                        dwell_q   <= CNT_ZERO;
                        state_q   <= SCAN;
                    end
                end
                HELD: begin
                    if (!cap_hit_d) begin
                        cnt_q   <= CNT_ZERO;
                        state_q <= REL_DB;
                    end else begin
                        key_valid_q <= rpt_fire_d;
                    end
                end
                REL_DB: begin
                    if (cap_hit_d) begin
                        cnt_q   <= CNT_ZERO;
                        state_q <= HELD;
                    end else if (cnt_inc_d == CNT_W'(DEBOUNCE_CYCLES)) begin
                        key_held_q <= 1'b0;
                        cnt_q      <= CNT_ZERO;
                        row_idx_q  <= row_nxt_d;
                        row_out_q  <= row_onehot(row_nxt_d);
                        dwell_q    <= CNT_ZERO;
                        state_q    <= SCAN;
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                default: begin
                    state_q <= SCAN;
                end
            endcase
        end
    end

    assign row_out   = row_out_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: key-press vector table, corner sequences and random presses
// checked every cycle against a behavioural keypad model.
module tb_keypad_scan_ctrl;

    localparam int DB    = 4;
    localparam int DWELL = 4;
    localparam int RDLY  = 16;
    localparam int RPER  = 8;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif
    localparam logic [47:0] KEYMAP = {4'hB, 4'h0, 4'hA, 4'h9, 4'h8, 4'h7,
                                      4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
    localparam logic [6:0]  BOUNCE = 7'b1111011;
    localparam int LOOK = 0, CONFIRM = 1, DOWN = 2, LIFT = 3;

    typedef struct packed {
        int         phase;
        int         row;
        int         tick;
        int         col;
        int         good;
        int         ht;
        logic [3:0] code;
        logic       valid;
        logic       held;
    } mdl_t;

    typedef struct {
        int         row;
        int         col;
        int         hold;
        bit         bounce;
        logic [3:0] code;
        int         p_def;
        int         p_ar;
    } vec_t;

    logic       clk = 1'b0;
    logic       clear;
    logic [3:0] row_out;
    logic [2:0] col_in;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [11:0] keys;
    logic [2:0]  ms1, ms2;
    mdl_t        m;
    int          n_checks = 0;
    int          n_pass = 0;
    int          pulses = 0;
    logic [3:0]  last_code = 4'h0;
    vec_t        vecs[8];

    keypad_scan_ctrl #(
        .DEBOUNCE_CYCLES(DB), .SCAN_DWELL(DWELL), .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER)
    ) dut (
        .clk(clk), .clear(clear), .row_out(row_out), .col_in(col_in),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clk = ~clk;

    // Keypad behaviour described as a sequence of phases per accepted key.
    function automatic mdl_t model_next(mdl_t cur, logic clr, logic [2:0] cs);
        mdl_t n;
        n = cur;
        n.valid = 1'b0;
        if (clr) begin
            n = '0;
        end else begin
            case (cur.phase)
                LOOK: begin
                    if (cur.tick < DWELL - 1) begin
                        n.tick = cur.tick + 1;
                    end else begin
                        n.tick = 0;
                        if ($countones(cs) == 1) begin
                            n.col   = cs[0] ? 0 : (cs[1] ? 1 : 2);
                            n.good  = 0;
                            n.phase = CONFIRM;
                        end else begin
                            n.row = (cur.row + 1) % 4;
                        end
                    end
                end
                CONFIRM: begin
                    if (cs == 3'(1 << cur.col)) begin
                        n.good = cur.good + 1;
                        if (n.good >= DB) begin
                            n.code  = KEYMAP[(cur.row * 3 + cur.col) * 4 +: 4];
                            n.valid = 1'b1;
                            n.held  = 1'b1;
                            n.ht    = 0;
                            n.phase = DOWN;
                        end
                    end else begin
                        n.phase = LOOK;
                        n.row   = (cur.row + 1) % 4;
                        n.tick  = 0;
                    end
                end
                DOWN: begin
                    if (cs[2'(cur.col)] == 1'b0) begin
                        n.good  = 0;
                        n.phase = LIFT;
                    end else begin
                        n.ht = cur.ht + 1;
                        if (AR && cur.code <= 4'h9 && n.ht >= RDLY && ((n.ht - RDLY) % RPER) == 0)
                            n.valid = 1'b1;
                    end
                end
                LIFT: begin
                    if (cs[2'(cur.col)] == 1'b0) begin
                        n.good = cur.good + 1;
                        if (n.good >= DB) begin
                            n.held  = 1'b0;
                            n.phase = LOOK;
                            n.row   = (cur.row + 1) % 4;
                            n.tick  = 0;
                        end
                    end else begin
                        n.good  = 0;
                        n.ht    = 0;
                        n.phase = DOWN;
                    end
                end
                default: n = '0;
            endcase
        end
        return n;
    endfunction

    always @(posedge clk) begin
        ms1 <= clear ? 3'b000 : col_in;
        ms2 <= clear ? 3'b000 : ms1;
        m   <= model_next(m, clear, ms2);
    end

    function automatic logic [2:0] cols_for(logic [3:0] ro, logic [11:0] k);
        logic [2:0] c;
        c = 3'b000;
        for (int r = 0; r < 4; r++)
            if (ro[r]) c = c | k[r * 3 +: 3];
        return c;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic check4(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        col_in = cols_for(row_out, keys);
        check4("row_out", row_out, 4'(1 << m.row));
        check4("key_code", key_code, m.code);
        check4("key_valid", {3'b000, key_valid}, {3'b000, m.valid});
        check4("key_held", {3'b000, key_held}, {3'b000, m.held});
        if (key_valid === 1'b1) begin
            pulses++;
            last_code = key_code;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press_release(input vec_t v, output int np, output logic [3:0] code);
        int  p0;
        bit  got;
        logic [3:0] target;
        p0 = pulses;
        target = 4'(1 << v.row);
        keys = 12'h000;
        if (v.bounce) begin
            for (int i = 0; i < 64; i++) begin
                if (row_out == target) break;
                step();
            end
            check4("bounce_row_reached", row_out, target);
            for (int i = 0; i < 7; i++) begin
                keys[4'(v.row * 3 + v.col)] = BOUNCE[i];
                step();
            end
        end
        keys[4'(v.row * 3 + v.col)] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            step();
            got = (key_valid === 1'b1);
        end
        check("accept_seen", int'(got), 1);
        steps(v.hold);
        keys = 12'h000;
        for (int i = 0; i < 200 && key_held !== 1'b0; i++) step();
        check4("release_done", {3'b000, key_held}, 4'h0);
        steps(4);
        np   = pulses - p0;
        code = last_code;
    endtask

    initial begin
        int         np;
        int         p0;
        bit         moved;
        logic [3:0] code;
        vec_t       v;

        vecs[0] = '{1, 2, 40, 1'b0, 4'h6, 1, 5};
        vecs[1] = '{2, 0, 10, 1'b1, 4'h7, 1, 1};
        vecs[2] = '{3, 2, 12, 1'b0, 4'hB, 1, 1};
        vecs[3] = '{0, 0, 20, 1'b0, 4'h1, 1, 2};
        vecs[4] = '{3, 0, 50, 1'b0, 4'hA, 1, 1};
        vecs[5] = '{0, 1, 50, 1'b0, 4'h2, 1, 6};
        vecs[6] = '{3, 1,  8, 1'b0, 4'h0, 1, 1};
        vecs[7] = '{2, 2,  5, 1'b0, 4'h9, 1, 1};

        clear  = 1'b1;
        keys   = 12'h000;
        col_in = 3'b000;
        steps(2);
        clear = 1'b0;
        check4("reset_row", row_out, 4'b0001);
        check4("reset_code", key_code, 4'h0);
        check4("reset_valid", {3'b000, key_valid}, 4'h0);
        check4("reset_held", {3'b000, key_held}, 4'h0);
        for (int k = 1; k < 16; k++) begin
            step();
            check4("idle_rotation", row_out, 4'(1 << ((k / 4) % 4)));
        end

        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            press_release(v, np, code);
            check("vec_pulses", np, AR ? v.p_ar : v.p_def);
            check4("vec_code", code, v.code);
        end

        // Clear two samples into the press debounce of key 5.
        for (int i = 0; i < 64 && row_out == 4'b0010; i++) step();
        for (int i = 0; i < 64 && row_out != 4'b0010; i++) step();
        p0 = pulses;
        keys = 12'h000;
        keys[4] = 1'b1;
        steps(6);
        clear = 1'b1;
        keys  = 12'h000;
        step();
        clear = 1'b0;
        check4("midpress_row", row_out, 4'b0001);
        check4("midpress_code", key_code, 4'h0);
        steps(12);
        check("midpress_pulses", pulses - p0, 0);

        // Two keys on row 0 form a multi-hot column pattern.
        p0 = pulses;
        moved = 1'b0;
        keys = 12'b000000000011;
        for (int i = 0; i < 24; i++) begin
            step();
            if (row_out == 4'b0010) moved = 1'b1;
        end
        check("ghost_pulses", pulses - p0, 0);
        check("ghost_row_advanced", int'(moved), 1);
        check4("ghost_held", {3'b000, key_held}, 4'h0);
        keys = 12'h000;
        steps(4);
        press_release('{3, 2, 6, 1'b0, 4'hB, 1, 1}, np, code);
        check("ghost_then_start_pulses", np, 1);
        check4("ghost_then_start_code", code, 4'hB);

        for (int it = 0; it < 40; it++) begin
            keys = 12'h000;
            case ($urandom_range(0, 3))
                0:       keys = 12'h000;
                3:       begin
                             keys[4'($urandom_range(0, 11))] = 1'b1;
                             keys[4'($urandom_range(0, 11))] = 1'b1;
                         end
                default: keys[4'($urandom_range(0, 11))] = 1'b1;
            endcase
            steps($urandom_range(1, 30));
            if ($urandom_range(0, 9) == 0) begin
                clear = 1'b1;
                step();
                clear = 1'b0;
            end
        end
        keys = 12'h000;
        steps(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Scans the microwave's 4x3 front-panel key matrix and turns the raw column lines into one debounced key event per press. All twelve keys share a single debounce counter: the controller drives one row at a time, locks onto the first valid key, debounces its press and release, then resumes scanning. It sits in the decoder between the panel pins and the time-entry/command logic, which consumes `key_code`/`key_valid`.

Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive matching samples required to accept a press or a release. Must be ≥1.
- `SCAN_DWELL`, default 4: cycles each row is driven before its columns are sampled. Must be ≥3, to cover synchroniser latency.
- `REPEAT_DELAY`, default 16: hold cycles before the first auto-repeat (`KEYPAD_AUTOREPEAT_EN` only).
- `REPEAT_PERIOD`, default 8: cycles between subsequent repeats (`KEYPAD_AUTOREPEAT_EN` only).

Ports:
- `clk`  in  1: single clock; every flop is on its rising edge.
- `clear`  in  1: synchronous, active-high reset.
- `row_out`  out  4: one-hot active-high row drive.
- `col_in`  in  3: raw column sense, active-high, asynchronous to `clk`.
- `key_code`  out  4: code of the accepted key.
- `key_valid`  out  1: one-cycle pulse per accepted key event.
- `key_held`  out  1: high while the accepted key is held.

Behaviour:
- **Synchroniser.** `col_in` passes through a 2-flop synchroniser; `col_s` denotes the synchronised value. All decisions use `col_s`.
- **Key map**, row r / col c:
  - r0 = 1, 2, 3
  - r1 = 4, 5, 6
  - r2 = 7, 8, 9
  - r3 = CANCEL (4'hA), 0, START (4'hB)
- **Reset** (`clear`=1 at a clock edge):
  - state=SCAN, row_idx=0, `row_out`=4'b0001.
  - `key_code`=0, `key_valid`=0, `key_held`=0.
  - All counters 0.
  - Takes priority over everything. Mid-operation reset discards the captured key and emits no pulse.
- **SCAN**
  - `row_out` = one-hot(row_idx). The dwell counter runs 0..`SCAN_DWELL`-1.
  - At the last dwell cycle, if `col_s` is exactly one-hot: capture row_idx and col, zero the debounce counter, go to PRESS_DB.
  - If `col_s` is zero or multi-hot (ghost or two keys): advance row_idx (3 wraps to 0) and restart dwell.
- **PRESS_DB**
  - Row held; the counter increments each cycle `col_s` equals the captured col one-hot.
  - Any mismatch returns to SCAN with row_idx advanced and no output.
  - When the counter reaches `DEBOUNCE_CYCLES`:
    - Next cycle: `key_code` = decoded key, `key_valid`=1 for exactly one cycle, `key_held`=1, go to HELD.
  - `key_code` is registered and holds its value until the next accepted key.
- **HELD**
  - `key_held`=1. Other columns and rows are ignored.
  - When the captured column bit of `col_s` goes 0: zero the counter, go to REL_DB.
- **REL_DB**
  - Captured bit must stay 0 for `DEBOUNCE_CYCLES` consecutive cycles. Then `key_held`=0 and go to SCAN with row_idx advanced.
  - If the bit reasserts first: back to HELD; no new `key_valid`, counter zeroed.
- **Width rule.** Counter width = `$clog2` of the largest count parameter, +1. Counters saturate and never wrap.
- **Simultaneous events.** A second key pressed during HELD/REL_DB is not reported; it is detectable only after release and rescan.

Optional Feature:
- **`KEYPAD_AUTOREPEAT_EN` defined:**
  - In HELD, for digit codes 0–9 only, a repeat counter starts at HELD entry.
  - After `REPEAT_DELAY` cycles, `key_valid` pulses with the same `key_code`, then every `REPEAT_PERIOD` cycles while held.
  - The counter resets on entering REL_DB; returning REL_DB→HELD restarts at `REPEAT_DELAY`.
  - CANCEL and START never repeat.
- **Undefined:** no repeat counter is synthesised; exactly one pulse per press.

Decomposition:
- **Shared package `keypad_pkg`:**
  - State enum {SCAN, PRESS_DB, HELD, REL_DB}.
  - Constants `NUM_ROWS`=4, `NUM_COLS`=3, `KEY_CANCEL`=4'hA, `KEY_START`=4'hB.
  - Function `key_decode(row, col)` returning 4-bit code.
- **Sub-module:** `sync_2ff` (parameterised width), for `col_in`. It is reused later for other panel inputs (door switch).

Test Plan:
1. Reset sequence:
   - Stimulus: `clear` 2 cycles, `col_in`=0.
   - Required: `row_out`=0001, rotating 0010→0100→1000→0001 every 4 cycles; `key_valid`/`key_held` never assert.
2. Clean press of row1/col2, held 40 cycles, then released:
   - Required: exactly one `key_valid` with `key_code`=4'h6; `key_held` high until 4 cycles after release; scanning resumes.
3. Bounce:
   - Stimulus: row2/col0 toggled 1,1,0,1,1,1,1 at the sampled row, then stable.
   - Required: no pulse from the first burst; single pulse with `key_code`=4'h7 after 4 clean samples.
4. Ghost/multi-key:
   - Stimulus: `col_in`=3'b011 on row0 only.
   - Required: no pulse, row advances.
   - Then: START (row3/col2) alone → `key_code`=4'hB, one pulse.
5. Reset mid-PRESS_DB:
   - Stimulus: `clear` pulse after 2 matching samples of key 5.
   - Required: no pulse, `row_out`=0001, `key_code`=0.
6. With `KEYPAD_AUTOREPEAT_EN`:
   - Stimulus: hold key 2 for 50 cycles.
   - Required: pulses at acceptance, +16, +24, +32, +40, +48.
   - Hold CANCEL 50 cycles → one pulse only.
